mean_square_accum: RTL
======================

MEAN_SQUARE_ACCUM -- requirements
Module: mean_square_accum

Interface
REQ-001 The block SHALL have parameter N_LOG2, default 4, giving a window length of 2^N_LOG2 samples; legal range is 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sample, input, 8 bits: the input sample.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: the sample is offered.
REQ-006 The block SHALL have port sample_ready, output, 1 bit: the block accepts the sample.
REQ-007 The block SHALL have port clear, input, 1 bit: discard the partial window.
REQ-008 The block SHALL have port num, output, 16 bits: the mean of squares over the window; this feeds the square-root stage's num input.
REQ-009 The block SHALL have port peak, output, 8 bits: the largest magnitude in the window.
REQ-010 The block SHALL have port num_valid, output, 1 bit: num and peak are valid.
REQ-011 The block SHALL have port num_ready, input, 1 bit: the downstream stage takes the result.

Function
REQ-012 The FSM SHALL have two states: ACCUM and HOLD.
REQ-013 sample_ready SHALL be 1 exactly when the state is ACCUM and clear is 0.
REQ-014 A sample SHALL be accepted in any cycle where sample_valid and sample_ready are both 1.
REQ-015 On acceptance, the block SHALL add the magnitude squared (0..65025) to acc, increment cnt, and update pk = max(pk, magnitude).
REQ-016 acc SHALL be 16+N_LOG2 bits wide so it never overflows; cnt SHALL be N_LOG2 bits wide.
REQ-017 When the accepted sample is number 2^N_LOG2 (cnt all-ones before the add), the next cycle SHALL show state HOLD, num = (acc + square) >> N_LOG2 truncated, peak = the final pk, and num_valid = 1.
REQ-018 Latency SHALL be exactly 1 cycle from acceptance of the last sample to num_valid.
REQ-019 In HOLD, num, peak and num_valid SHALL stay stable until num_ready = 1.
REQ-020 In HOLD with num_ready = 1, the next cycle SHALL show ACCUM, num_valid = 0, and acc, cnt and pk all 0; num and peak SHALL keep their old values.
REQ-021 No sample SHALL be accepted in the cycle of the HOLD-to-ACCUM transition.
REQ-022 In ACCUM, clear = 1 SHALL zero acc, cnt and pk and SHALL accept no sample, even if sample_valid = 1 in the same cycle (clear wins).
REQ-023 In HOLD, clear SHALL be ignored, so a pending result is never lost.
REQ-024 num_valid SHALL be a registered output; no output may depend combinationally on num_ready.

Reset
REQ-025 When rst = 1 at a clock edge, the block SHALL force state to ACCUM and acc, cnt, pk, num, peak and num_valid to 0.
REQ-026 Reset SHALL take priority over clear, over the handshakes, and over a pending HOLD; a partial or pending window is discarded.
REQ-027 sample_ready SHALL be 0 while rst = 1.

Configuration
REQ-028 With macro MEAN_SQUARE_SIGNED_EN defined, sample SHALL be two's complement and magnitude = |sample|, so -128 gives 128, square 16384, and peak 128.
REQ-029 Without MEAN_SQUARE_SIGNED_EN, sample SHALL be unsigned and magnitude = sample.

Structure
REQ-030 A shared package mean_square_pkg SHALL hold the state enum type (ACCUM, HOLD), the default N_LOG2 constant, and the sample and result width constants.
REQ-031 The design SHALL contain one sub-module, sq8, a combinational 8x8 to 16-bit unsigned squarer.
REQ-032 The accumulator, counter, peak register and FSM SHALL be in the top module.

Verification
REQ-033 With N_LOG2 = 4 and 16 samples of 10 with num_ready held 1, the bench SHALL see num = 100, peak = 10, and num_valid high for exactly 1 cycle, 1 cycle after the 16th acceptance.
REQ-034 With samples 0, 255 repeated (16 samples, unsigned), the bench SHALL see num = 32512 (520200 >> 4) and peak = 255.
REQ-035 With num_ready held 0 for 5 cycles after num_valid, the bench SHALL see sample_ready = 0 and num/peak stable throughout, and the next window starting from acc = 0 once num_ready = 1.
REQ-036 With clear asserted after 7 samples of 50, in the same cycle as sample_valid, that sample SHALL not be accepted, and the next 16 samples of 3 SHALL give num = 9 and peak = 3.
REQ-037 With rst asserted mid-window and while in HOLD, the next cycle SHALL show every output 0, state ACCUM, and sample_ready = 1 once rst = 0.
REQ-038 With MEAN_SQUARE_SIGNED_EN defined and 16 samples of -128, the bench SHALL see num = 16384 and peak = 128; without the macro, 0x80 SHALL give num = 16384 and peak = 128 as well, while -1 (0xFF) SHALL give num = 65025 versus 1 with the macro.

Source files
------------

// File: rtl/mean_square_pkg.sv
// ---------------------------------------------------------------------------
// mean_square_pkg
// Shared types and constants for the mean-of-squares accumulator.
//   ms_state_e     : FSM state encoding (ACCUM collects samples, HOLD offers
//                    the finished result downstream)
//   N_LOG2_DEFAULT : default log2 of the window length
//   SAMPLE_W       : width of an input sample
//   RESULT_W       : width of the mean-of-squares result (8x8 square width)
//   max_u8         : larger of two unsigned sample magnitudes
// ---------------------------------------------------------------------------
package mean_square_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ms_state_e;

    localparam int N_LOG2_DEFAULT = 4;
    localparam int SAMPLE_W       = 8;
    localparam int RESULT_W       = 16;

    function automatic logic [SAMPLE_W-1:0] max_u8(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        logic [SAMPLE_W-1:0] m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/mean_square_accum_sq8.sv
// ---------------------------------------------------------------------------
// sq8
// Combinational unsigned squarer: sq = a * a.
//   a  : 8-bit unsigned operand
//   sq : 16-bit unsigned square (max 255*255 = 65025, always fits)
// ---------------------------------------------------------------------------
module sq8
    import mean_square_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    output logic [RESULT_W-1:0] sq
);

    logic [RESULT_W-1:0] a_ext_s;

    assign a_ext_s = {8'd0, a};
    assign sq      = a_ext_s * a_ext_s;

endmodule

// File: rtl/mean_square_accum.sv
// ---------------------------------------------------------------------------
// mean_square_accum
// Accumulates the squared magnitude of 2^N_LOG2 samples and presents their
// mean (sum >> N_LOG2) together with the largest magnitude seen in the
// window. The result is held until the downstream stage takes it.
//
// Parameters
//   N_LOG2       : log2 of the window length, 1..8
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   sample       : input sample (unsigned, or two's complement if signed)
//   sample_valid : sample is offered
//   sample_ready : sample is accepted this cycle (ACCUM, no clear, no rst)
//   clear        : discard the partial window (ignored while holding)
//   num          : mean of squares over the last window (registered)
//   peak         : largest magnitude in the last window (registered)
//   num_valid    : num/peak are valid (registered)
//   num_ready    : downstream takes the result
//
// Build option
//   MEAN_SQUARE_SIGNED_EN : when defined, sample is two's complement and the
//                           magnitude is |sample| (-128 -> 128). Otherwise
//                           sample is unsigned and used as-is.
// ---------------------------------------------------------------------------
module mean_square_accum
    import mean_square_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                clear,
    output logic [RESULT_W-1:0] num,
    output logic [SAMPLE_W-1:0] peak,
    output logic                num_valid,
    input  logic                num_ready
);

    // Sum of up to 2^N_LOG2 squares of at most 65025 cannot overflow this.
    localparam int ACC_W = RESULT_W + N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_ONE = {{(N_LOG2-1){1'b0}}, 1'b1};

    ms_state_e           state_r;
    ms_state_e           state_next_s;
    logic [ACC_W-1:0]    acc_r;
    logic [N_LOG2-1:0]   cnt_r;
    logic [SAMPLE_W-1:0] pk_r;
    logic [RESULT_W-1:0] num_r;
    logic [SAMPLE_W-1:0] peak_r;
    logic                num_valid_r;

    logic                sample_ready_s;
    logic                accept_s;
    logic                last_s;
    logic [SAMPLE_W-1:0] mag_s;
    logic [RESULT_W-1:0] sq_s;
    logic [ACC_W-1:0]    sum_s;
    logic [SAMPLE_W-1:0] pk_next_s;

    // Sample magnitude: absolute value in the signed build, identity otherwise.
    always_comb begin
        mag_s = sample;
`ifdef MEAN_SQUARE_SIGNED_EN
        if (sample[SAMPLE_W-1]) begin
            // -128 negates to 8'h80, which read unsigned is the correct 128.
            mag_s = (~sample) + 8'd1;
        end else begin
            mag_s = sample;
        end
`endif
    end

    sq8 u_sq8 (
        .a  (mag_s),
        .sq (sq_s)
    );

    assign accept_s  = sample_valid & sample_ready_s;
    assign last_s    = &cnt_r;
    assign sum_s     = acc_r + {{N_LOG2{1'b0}}, sq_s};
    assign pk_next_s = max_u8(pk_r, mag_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ACCUM;
        case (state_r)
            ACCUM: begin
                if (accept_s && last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (num_ready) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = ACCUM;
        endcase
    end

    // FSM output logic: accept only while collecting and not clearing.
    always_comb begin
        sample_ready_s = 1'b0;
        if ((state_r == ACCUM) && !clear && !rst) begin
            sample_ready_s = 1'b1;
        end else begin
            sample_ready_s = 1'b0;
        end
    end

    // Accumulator, counter, running peak and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {N_LOG2{1'b0}};
            pk_r        <= 8'd0;
            num_r       <= 16'd0;
            peak_r      <= 8'd0;
            num_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (clear) begin
                        acc_r <= {ACC_W{1'b0}};
                        cnt_r <= {N_LOG2{1'b0}};
                        pk_r  <= 8'd0;
                    end else if (accept_s && last_s) begin
                        // Window complete: publish and start the next window empty.
                        num_r       <= sum_s[N_LOG2 +: RESULT_W];
                        peak_r      <= pk_next_s;
                        num_valid_r <= 1'b1;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= {N_LOG2{1'b0}};
                        pk_r        <= 8'd0;
                    end else if (accept_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        pk_r  <= pk_next_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    // clear is deliberately ignored here so the result is not lost.
                    if (num_ready) begin
                        num_valid_r <= 1'b0;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= {N_LOG2{1'b0}};
                        pk_r        <= 8'd0;
                    end else begin
                        num_valid_r <= 1'b1;
                    end
                end
                default: begin
                    num_valid_r <= 1'b0;
                    acc_r       <= {ACC_W{1'b0}};
                    cnt_r       <= {N_LOG2{1'b0}};
                    pk_r        <= 8'd0;
                end
            endcase
        end
    end

    assign sample_ready = sample_ready_s;
    assign num          = num_r;
    assign peak         = peak_r;
    assign num_valid    = num_valid_r;

endmodule
